// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer FSM states, redirect causes and
// default widths for the program-counter stage.
package cpu_pkg;

  localparam int PC_W_DEF     = 10;
  localparam int RESET_PC_DEF = 0;

  // Program-counter stage FSM states.
  typedef enum logic [1:0] {
    ST_RUN,
    ST_BUBBLE,
    ST_HALT
  } seq_state_t;

  // Reason the next pc departs from pc+1.
  typedef enum logic [2:0] {
    CAUSE_NONE,
    CAUSE_BR,
    CAUSE_JMP,
    CAUSE_CALL,
    CAUSE_RET
  } redirect_cause_t;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: LIFO register array plus an occupancy count.
// A push while full or a pop while empty is ignored here; the caller
// decides what that means architecturally.
module pc_ras
  import cpu_pkg::*;
#(
  parameter int RAS_DEPTH = 4,
  parameter int PC_W      = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int AW = $clog2(RAS_DEPTH);

  logic [PC_W-1:0] mem [RAS_DEPTH];
  logic [AW:0]     count;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;

  assign wr_idx = count[AW-1:0];
  assign rd_idx = AW'(count - 1'b1);
  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(RAS_DEPTH));
  assign top    = mem[rd_idx];

  // Occupancy count; push takes precedence (the two never coincide in use).
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + 1'b1;
    end else if (pop && !empty) begin
      count <= count - 1'b1;
    end
  end

  // Entry storage; contents past the count are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: holds pc, applies branch/jump/call/return
// redirects with a one-cycle fetch bubble after each, and keeps a small
// return-address stack. stall=1 freezes every register, including the
// bubble and the sticky ras_err flag; inputs seen during a stall are lost.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_en,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            halt,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            ras_err,
  output logic            halted
);

  seq_state_t      state;
  redirect_cause_t cause;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] ras_top;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_push;
  logic            ras_pop;
  logic            decide;

  // Wraps modulo 2^PC_W by construction.
  assign pc_inc = pc + 1'b1;

  // A control decision is taken only in RUN, unstalled, and not halting.
  assign decide = (state == ST_RUN) && !stall && !halt;

  // Highest-priority redirect cause; lower ones are discarded.
  always_comb begin
    cause = CAUSE_NONE;
    if (ret) begin
      cause = CAUSE_RET;
    end else if (call) begin
      cause = CAUSE_CALL;
    end else if (jmp) begin
      cause = CAUSE_JMP;
    end else if (br_en && br_taken) begin
      cause = CAUSE_BR;
    end
  end

  assign ras_push = decide && (cause == CAUSE_CALL) && !ras_full;
  assign ras_pop  = decide && (cause == CAUSE_RET) && !ras_empty;

  pc_ras #(
    .RAS_DEPTH(RAS_DEPTH),
    .PC_W     (PC_W)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(pc_inc),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

  // Sequencer FSM with registered pc, pc_valid, ras_err and halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      pc       <= RESET_PC;
      pc_valid <= 1'b1;
      ras_err  <= 1'b0;
      halted   <= 1'b0;
    end else if (!stall) begin
      case (state)
        ST_RUN: begin
          if (halt) begin
            state    <= ST_HALT;
            pc_valid <= 1'b0;
            halted   <= 1'b1;
          end else begin
            case (cause)
              CAUSE_RET: begin
                if (ras_empty) begin
                  // Underflow: flag it and fall through sequentially.
                  ras_err <= 1'b1;
                  pc      <= pc_inc;
                end else begin
                  pc       <= ras_top;
                  state    <= ST_BUBBLE;
                  pc_valid <= 1'b0;
                end
              end
              CAUSE_CALL: begin
                // Overflow drops the push but still redirects.
                if (ras_full) ras_err <= 1'b1;
                pc       <= jmp_target;
                state    <= ST_BUBBLE;
                pc_valid <= 1'b0;
              end
              CAUSE_JMP: begin
                pc       <= jmp_target;
                state    <= ST_BUBBLE;
                pc_valid <= 1'b0;
              end
              CAUSE_BR: begin
                pc       <= br_target;
                state    <= ST_BUBBLE;
                pc_valid <= 1'b0;
              end
              default: pc <= pc_inc;
            endcase
          end
        end
        ST_BUBBLE: begin
          state    <= ST_RUN;
          pc_valid <= 1'b1;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a directed vector table for the scenario
// walk-throughs, then randomized traffic checked against a behavioural model.
module tb_pc_sequencer;
  import cpu_pkg::*;

  localparam int PC_W      = 10;
  localparam int RAS_DEPTH = 4;
  localparam int N_RAND    = 3000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, stall, br_en, br_taken, jmp, call, ret, halt;
  logic [PC_W-1:0] br_target, jmp_target;
  logic [PC_W-1:0] pc;
  logic            pc_valid, ras_err, halted;

  pc_sequencer #(
    .PC_W     (PC_W),
    .RESET_PC ('0),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br_en     (br_en),
    .br_taken  (br_taken),
    .br_target (br_target),
    .jmp       (jmp),
    .call      (call),
    .ret       (ret),
    .jmp_target(jmp_target),
    .halt      (halt),
    .pc        (pc),
    .pc_valid  (pc_valid),
    .ras_err   (ras_err),
    .halted    (halted)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [PC_W+2:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [PC_W+2:0] e);
    check({tag, ".pc"},       32'(pc),       32'(e[PC_W+2:3]));
    check({tag, ".pc_valid"}, 32'(pc_valid), 32'(e[2]));
    check({tag, ".ras_err"},  32'(ras_err),  32'(e[1]));
    check({tag, ".halted"},   32'(halted),   32'(e[0]));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic            rst, stall, br_en, br_taken, jmp, call, ret, halt;
    logic [PC_W-1:0] br_target, jmp_target;
    logic [PC_W-1:0] e_pc;
    logic            e_valid, e_err, e_halted;
  } vec_t;

  vec_t vec_q[$];

  task automatic add(input string kind, input int tgt, input int e_pc,
                     input bit e_valid, input bit e_err, input bit e_halted);
    vec_t v;
    v = '{default: '0};
    case (kind)
      "rst":   v.rst = 1'b1;
      "rs":    begin v.rst = 1'b1; v.stall = 1'b1; end
      "br":    begin v.br_en = 1'b1; v.br_taken = 1'b1; v.br_target = PC_W'(tgt); end
      "nbr":   begin v.br_en = 1'b1; v.br_target = PC_W'(tgt); end
      "jmp":   begin v.jmp = 1'b1; v.jmp_target = PC_W'(tgt); end
      "call":  begin v.call = 1'b1; v.jmp_target = PC_W'(tgt); end
      "ret":   v.ret = 1'b1;
      "hj":    begin v.halt = 1'b1; v.jmp = 1'b1; v.jmp_target = PC_W'(tgt); end
      "stall": v.stall = 1'b1;
      "scall": begin v.stall = 1'b1; v.call = 1'b1; v.jmp_target = PC_W'(tgt); end
      default: ;
    endcase
    v.e_pc     = PC_W'(e_pc);
    v.e_valid  = e_valid;
    v.e_err    = e_err;
    v.e_halted = e_halted;
    vec_q.push_back(v);
  endtask

  task automatic drive_idle();
    rst = 0; stall = 0; br_en = 0; br_taken = 0; jmp = 0; call = 0; ret = 0; halt = 0;
    br_target = '0; jmp_target = '0;
  endtask

  // Driver: inputs change on the falling edge, outputs are checked 1ns after the rising edge.
  task automatic apply_vec(input int idx, input vec_t v);
    @(negedge clk);
    rst = v.rst; stall = v.stall; br_en = v.br_en; br_taken = v.br_taken;
    jmp = v.jmp; call = v.call; ret = v.ret; halt = v.halt;
    br_target = v.br_target; jmp_target = v.jmp_target;
    @(posedge clk);
    #1;
    check_outputs($sformatf("vec%0d", idx), {v.e_pc, v.e_valid, v.e_err, v.e_halted});
  endtask

  // ---------------- behavioural reference model ----------------
  int   m_pc;
  bit   m_bubble, m_halted, m_err;
  int   m_stack[$];

  function automatic void model_reset();
    m_pc = 0; m_bubble = 0; m_halted = 0; m_err = 0;
    m_stack.delete();
  endfunction

  function automatic void model_step();
    if (rst) begin
      model_reset();
    end else if (stall || m_halted) begin
      // nothing moves
    end else if (m_bubble) begin
      m_bubble = 0;
    end else if (halt) begin
      m_halted = 1;
    end else if (ret) begin
      if (m_stack.size() > 0) begin
        m_pc = m_stack.pop_back();
        m_bubble = 1;
      end else begin
        m_err = 1;
        m_pc = (m_pc + 1) % (1 << PC_W);
      end
    end else if (call) begin
      if (m_stack.size() < RAS_DEPTH) m_stack.push_back((m_pc + 1) % (1 << PC_W));
      else m_err = 1;
      m_pc = int'(jmp_target);
      m_bubble = 1;
    end else if (jmp) begin
      m_pc = int'(jmp_target);
      m_bubble = 1;
    end else if (br_en && br_taken) begin
      m_pc = int'(br_target);
      m_bubble = 1;
    end else begin
      m_pc = (m_pc + 1) % (1 << PC_W);
    end
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    drive_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.pc",       32'(pc),       32'h0);
    check("reset.pc_valid", 32'(pc_valid), 32'h1);
    check("reset.ras_err",  32'(ras_err),  32'h0);
    check("reset.halted",   32'(halted),   32'h0);

    // free run
    for (int i = 1; i <= 5; i++) add("-", 0, i, 1, 0, 0);
    // taken branch at pc=3
    add("rst", 0, 0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) add("-", 0, i, 1, 0, 0);
    add("br", 'h040, 'h040, 0, 0, 0);
    add("-", 0, 'h040, 1, 0, 0);
    add("-", 0, 'h041, 1, 0, 0);
    // not-taken branch at pc=3
    add("rst", 0, 0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) add("-", 0, i, 1, 0, 0);
    add("nbr", 'h040, 4, 1, 0, 0);
    add("-", 0, 5, 1, 0, 0);
    // call / return
    add("jmp", 'h010, 'h010, 0, 0, 0);
    add("-", 0, 'h010, 1, 0, 0);
    add("call", 'h100, 'h100, 0, 0, 0);
    add("-", 0, 'h100, 1, 0, 0);
    add("-", 0, 'h101, 1, 0, 0);
    add("-", 0, 'h102, 1, 0, 0);
    add("ret", 0, 'h011, 0, 0, 0);
    add("-", 0, 'h011, 1, 0, 0);
    // control during a bubble is ignored
    add("jmp", 'h080, 'h080, 0, 0, 0);
    add("br", 'h090, 'h080, 1, 0, 0);
    add("-", 0, 'h081, 1, 0, 0);
    // nested calls, overflow on the fifth
    add("call", 'h020, 'h020, 0, 0, 0); add("-", 0, 'h020, 1, 0, 0);
    add("call", 'h030, 'h030, 0, 0, 0); add("-", 0, 'h030, 1, 0, 0);
    add("call", 'h040, 'h040, 0, 0, 0); add("-", 0, 'h040, 1, 0, 0);
    add("call", 'h050, 'h050, 0, 0, 0); add("-", 0, 'h050, 1, 0, 0);
    add("call", 'h060, 'h060, 0, 1, 0); add("-", 0, 'h060, 1, 1, 0);
    // unwinding, underflow on the fifth
    add("ret", 0, 'h041, 0, 1, 0); add("-", 0, 'h041, 1, 1, 0);
    add("ret", 0, 'h031, 0, 1, 0); add("-", 0, 'h031, 1, 1, 0);
    add("ret", 0, 'h021, 0, 1, 0); add("-", 0, 'h021, 1, 1, 0);
    add("ret", 0, 'h082, 0, 1, 0); add("-", 0, 'h082, 1, 1, 0);
    add("ret", 0, 'h083, 1, 1, 0);
    add("-", 0, 'h084, 1, 1, 0);
    // wrap at top of address space
    add("jmp", 'h3FF, 'h3FF, 0, 1, 0);
    add("-", 0, 'h3FF, 1, 1, 0);
    add("-", 0, 'h000, 1, 1, 0);
    add("-", 0, 'h001, 1, 1, 0);
    // stall held across a bubble, and a call lost to a stall
    add("jmp", 'h200, 'h200, 0, 1, 0);
    for (int i = 0; i < 3; i++) add("stall", 0, 'h200, 0, 1, 0);
    add("-", 0, 'h200, 1, 1, 0);
    add("-", 0, 'h201, 1, 1, 0);
    add("scall", 'h300, 'h201, 1, 1, 0);
    add("-", 0, 'h202, 1, 1, 0);
    // reset clears the error; reset beats stall
    add("rst", 0, 0, 1, 0, 0);
    add("ret", 0, 1, 1, 1, 0);
    add("rs", 0, 0, 1, 0, 0);
    add("-", 0, 1, 1, 0, 0);
    // reset during a bubble, and reset empties the stack
    add("jmp", 'h055, 'h055, 0, 0, 0);
    add("rst", 0, 0, 1, 0, 0);
    add("-", 0, 1, 1, 0, 0);
    add("call", 'h020, 'h020, 0, 0, 0);
    add("rst", 0, 0, 1, 0, 0);
    add("ret", 0, 1, 1, 1, 0);
    // halt wins over jmp at pc=7, then ignores everything until reset
    add("rst", 0, 0, 1, 0, 0);
    for (int i = 1; i <= 7; i++) add("-", 0, i, 1, 0, 0);
    add("hj", 'h100, 7, 0, 0, 1);
    add("jmp", 'h100, 7, 0, 0, 1);
    add("ret", 0, 7, 0, 0, 1);
    add("-", 0, 7, 0, 0, 1);
    add("rst", 0, 0, 1, 0, 0);
    add("-", 0, 1, 1, 0, 0);

    foreach (vec_q[i]) apply_vec(i, vec_q[i]);

    // randomized traffic against the model
    @(negedge clk);
    drive_idle();
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs("rand_reset", {PC_W'(m_pc), 1'b1, 1'b0, 1'b0});

    for (int n = 0; n < N_RAND; n++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 199) == 0);
      stall      = ($urandom_range(0, 9) < 2);
      halt       = ($urandom_range(0, 299) == 0);
      ret        = ($urandom_range(0, 9) < 2);
      call       = ($urandom_range(0, 9) < 2);
      jmp        = ($urandom_range(0, 9) < 1);
      br_en      = ($urandom_range(0, 9) < 3);
      br_taken   = $urandom_range(0, 1) == 1;
      br_target  = PC_W'($urandom_range(0, (1 << PC_W) - 1));
      jmp_target = PC_W'($urandom_range(0, (1 << PC_W) - 1));
      model_step();
      exp_q.push_back({PC_W'(m_pc), !(m_bubble || m_halted), m_err, m_halted});
      @(posedge clk);
      #1;
      check_outputs($sformatf("rand%0d", n), exp_q.pop_front());
    end

    @(negedge clk);
    drive_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
